// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: default widths, ALU op codes and the MUL FSM states.
package ex_stage_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int ADDR_W_DEF    = 14;
    localparam int MUL_ITERS_DEF = 32;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;
    localparam logic [3:0] ALU_MUL   = 4'd11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mul_state_e;

endpackage

// File: rtl/ex_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per cycle, low XLEN bits of the product.
// The product output is combinational so the final step lands in EX/MEM on the completing edge.
module ex_mul_seq
    import ex_stage_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int MUL_ITERS = MUL_ITERS_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            abort,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            last,
    output logic [XLEN-1:0] product
);

    localparam int CNT_W = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;

    mul_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [XLEN-1:0]  acc_r;
    logic [XLEN-1:0]  mcand_r;
    logic [XLEN-1:0]  mplier_r;
    logic [XLEN-1:0]  acc_next_s;

    // Accumulate the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    assign busy    = (state_r == ST_BUSY);
    assign last    = busy && (cnt_r == CNT_W'(MUL_ITERS - 1));
    assign product = acc_next_s;

    // FSM, iteration counter and partial-product registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
        end else if (abort) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r  <= ST_BUSY;
                        cnt_r    <= '0;
                        acc_r    <= '0;
                        mcand_r  <= a;
                        mplier_r <= b;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    if (last) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// RV32 execute stage: operand forwarding, combinational ALU, iterative MUL and the EX/MEM register.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int MUL_ITERS = MUL_ITERS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              RegWrite_i,
    input  logic              ALUSrc_i,
    input  logic [3:0]        ALUControl_i,
    input  logic [XLEN-1:0]   imme_i,
    input  logic [XLEN-1:0]   rdata1_i,
    input  logic [XLEN-1:0]   rdata2_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [4:0]        rd_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              flush_i,
    input  logic              wb_regwrite_i,
    input  logic [4:0]        wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic              stall_o,
    output logic              valid_o,
    output logic              RegWrite_o,
    output logic [4:0]        rd_o,
    output logic [XLEN-1:0]   result_o,
    output logic [XLEN-1:0]   store_data_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [XLEN-1:0] fwd_a_s;
    logic [XLEN-1:0] fwd_b_s;
    logic [XLEN-1:0] op_b_s;
    logic [XLEN-1:0] alu_s;
    logic [XLEN-1:0] product_s;
    logic [XLEN-1:0] load_result_s;
    logic [4:0]      shamt_s;
    logic            exm_fwd_ok_s;
    logic            wb_fwd_ok_s;
    logic            is_mul_s;
    logic            mul_start_s;
    logic            mul_busy_s;
    logic            mul_last_s;
    logic            load_s;

    assign exm_fwd_ok_s = RegWrite_o && valid_o && (rd_o != 5'd0);
    assign wb_fwd_ok_s  = wb_regwrite_i && (wb_rd_i != 5'd0);

    // Operand selection: EX/MEM wins over MEM/WB, both over the register file
    always_comb begin
        fwd_a_s = rdata1_i;
        fwd_b_s = rdata2_i;
        if (exm_fwd_ok_s && (rd_o == rs1_i)) begin
            fwd_a_s = result_o;
        end else if (wb_fwd_ok_s && (wb_rd_i == rs1_i)) begin
            fwd_a_s = wb_data_i;
        end else begin
            fwd_a_s = rdata1_i;
        end
        if (exm_fwd_ok_s && (rd_o == rs2_i)) begin
            fwd_b_s = result_o;
        end else if (wb_fwd_ok_s && (wb_rd_i == rs2_i)) begin
            fwd_b_s = wb_data_i;
        end else begin
            fwd_b_s = rdata2_i;
        end
    end

    assign op_b_s  = ALUSrc_i ? imme_i : fwd_b_s;
    assign shamt_s = op_b_s[4:0];

    // Single-cycle ALU; MUL goes through the iterative unit instead
    always_comb begin
        alu_s = '0;
        case (ALUControl_i)
            ALU_ADD:   alu_s = fwd_a_s + op_b_s;
            ALU_SUB:   alu_s = fwd_a_s - op_b_s;
            ALU_AND:   alu_s = fwd_a_s & op_b_s;
            ALU_OR:    alu_s = fwd_a_s | op_b_s;
            ALU_XOR:   alu_s = fwd_a_s ^ op_b_s;
            ALU_SLL:   alu_s = fwd_a_s << shamt_s;
            ALU_SRL:   alu_s = fwd_a_s >> shamt_s;
            ALU_SRA:   alu_s = $unsigned($signed(fwd_a_s) >>> shamt_s);
            ALU_SLT:   alu_s = {{(XLEN-1){1'b0}}, ($signed(fwd_a_s) < $signed(op_b_s))};
            ALU_SLTU:  alu_s = {{(XLEN-1){1'b0}}, (fwd_a_s < op_b_s)};
            ALU_PASSB: alu_s = op_b_s;
            default:   alu_s = '0;
        endcase
    end

    assign is_mul_s    = (ALUControl_i == ALU_MUL);
    assign mul_start_s = valid_i && is_mul_s && !flush_i && !mul_busy_s;

    ex_mul_seq #(
        .XLEN      (XLEN),
        .MUL_ITERS (MUL_ITERS)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .abort   (flush_i),
        .start   (mul_start_s),
        .a       (fwd_a_s),
        .b       (op_b_s),
        .busy    (mul_busy_s),
        .last    (mul_last_s),
        .product (product_s)
    );

    // Front end holds while a MUL is starting or iterating, except on its final cycle
    assign stall_o = rst_n && !flush_i && (mul_start_s || (mul_busy_s && !mul_last_s));

    assign load_s        = !flush_i && (mul_busy_s ? mul_last_s : (valid_i && !is_mul_s));
    assign load_result_s = mul_busy_s ? product_s : alu_s;

    // EX/MEM register: a real instruction or a cleared bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_o      <= 1'b0;
            RegWrite_o   <= 1'b0;
            rd_o         <= 5'd0;
            result_o     <= '0;
            store_data_o <= '0;
            addr_o       <= '0;
        end else if (load_s) begin
            valid_o      <= 1'b1;
            RegWrite_o   <= RegWrite_i;
            rd_o         <= rd_i;
            result_o     <= load_result_s;
            store_data_o <= fwd_b_s;
            addr_o       <= addr_i;
        end else begin
            valid_o      <= 1'b0;
            RegWrite_o   <= 1'b0;
            rd_o         <= 5'd0;
            result_o     <= '0;
            store_data_o <= '0;
            addr_o       <= '0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, MUL/flush/reset sequences and a
// randomized run against an arithmetic reference model.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, RegWrite_i, ALUSrc_i, flush_i, wb_regwrite_i;
    logic [3:0]  ALUControl_i;
    logic [31:0] imme_i, rdata1_i, rdata2_i, wb_data_i;
    logic [4:0]  rs1_i, rs2_i, rd_i, wb_rd_i;
    logic [13:0] addr_i;
    logic        stall_o, valid_o, RegWrite_o;
    logic [4:0]  rd_o;
    logic [31:0] result_o, store_data_o;
    logic [13:0] addr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .RegWrite_i(RegWrite_i),
        .ALUSrc_i(ALUSrc_i), .ALUControl_i(ALUControl_i), .imme_i(imme_i),
        .rdata1_i(rdata1_i), .rdata2_i(rdata2_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .rd_i(rd_i), .addr_i(addr_i), .flush_i(flush_i), .wb_regwrite_i(wb_regwrite_i),
        .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .stall_o(stall_o), .valid_o(valid_o),
        .RegWrite_o(RegWrite_o), .rd_o(rd_o), .result_o(result_o),
        .store_data_o(store_data_o), .addr_o(addr_o)
    );

    typedef struct {
        logic        valid, rw, alusrc;
        logic [3:0]  op;
        logic [31:0] imme, rd1, rd2;
        logic [4:0]  rs1, rs2, rd;
        logic [13:0] addr;
        logic        wb_rw;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        e_valid, e_rw;
        logic [4:0]  e_rd;
        logic [31:0] e_res, e_store;
        logic [13:0] e_addr;
    } vec_t;

    vec_t tbl[16];

    // reference EX/MEM state and MUL progress
    logic        m_valid, m_rw;
    logic [4:0]  m_rd;
    logic [31:0] m_res, m_store, m_prod;
    logic [13:0] m_addr;
    bit          m_busy;
    int          m_left;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_i = 1'b0; RegWrite_i = 1'b0; ALUSrc_i = 1'b0; ALUControl_i = 4'd0;
        imme_i = 32'd0; rdata1_i = 32'd0; rdata2_i = 32'd0;
        rs1_i = 5'd0; rs2_i = 5'd0; rd_i = 5'd0; addr_i = 14'd0; flush_i = 1'b0;
        wb_regwrite_i = 1'b0; wb_rd_i = 5'd0; wb_data_i = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string name);
        chk({name, "_valid"}, 32'(valid_o), 32'd0);
        chk({name, "_rw"}, 32'(RegWrite_o), 32'd0);
        chk({name, "_rd"}, 32'(rd_o), 32'd0);
        chk({name, "_result"}, result_o, 32'd0);
        chk({name, "_store"}, store_data_o, 32'd0);
        chk({name, "_addr"}, 32'(addr_o), 32'd0);
    endtask

    task automatic set_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        idle_inputs();
        valid_i = 1'b1; RegWrite_i = 1'b1; ALUControl_i = ALU_MUL;
        rs1_i = 5'd1; rs2_i = 5'd2; rd_i = rd; rdata1_i = a; rdata2_i = b; addr_i = 14'h40;
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return $unsigned($signed(a) >>> b[4:0]);
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd10:   return b;
            4'd11:   return a * b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] rf);
        if (m_valid && m_rw && m_rd != 5'd0 && m_rd == rs) return m_res;
        if (wb_regwrite_i && wb_rd_i != 5'd0 && wb_rd_i == rs) return wb_data_i;
        return rf;
    endfunction

    initial begin
        int          stall_cnt, edges;
        bit          done, prev_stall, e_stall;
        logic [31:0] fa, fb, bb;

        // valid, rw, alusrc, op, imme, rd1, rd2, rs1, rs2, rd, addr, wb_rw, wb_rd, wb_data,
        // e_valid, e_rw, e_rd, e_res, e_store, e_addr
        tbl[0]  = '{1'b1,1'b1,1'b0,4'd0, 32'd0, 32'd5, 32'd7, 5'd1,5'd2,5'd3, 14'h10, 1'b0,5'd0,32'd0,
                    1'b1,1'b1,5'd3, 32'd12, 32'd7, 14'h10};
        tbl[1]  = '{1'b1,1'b1,1'b0,4'd1, 32'd0, 32'd0, 32'd5, 5'd3,5'd1,5'd4, 14'h14, 1'b1,5'd3,32'd99,
                    1'b1,1'b1,5'd4, 32'd7, 32'd5, 14'h14};
        tbl[2]  = '{1'b1,1'b1,1'b1,4'd0, 32'd3, 32'd1, 32'd9, 5'd6,5'd0,5'd5, 14'h18, 1'b1,5'd6,32'd100,
                    1'b1,1'b1,5'd5, 32'd103, 32'd9, 14'h18};
        tbl[3]  = '{1'b1,1'b1,1'b1,4'd0, 32'd0, 32'h55, 32'd0, 5'd7,5'd8,5'd0, 14'h1C, 1'b0,5'd0,32'd0,
                    1'b1,1'b1,5'd0, 32'h55, 32'd0, 14'h1C};
        tbl[4]  = '{1'b1,1'b1,1'b1,4'd0, 32'd4, 32'd0, 32'd0, 5'd0,5'd0,5'd6, 14'h20, 1'b1,5'd0,32'h77,
                    1'b1,1'b1,5'd6, 32'd4, 32'd0, 14'h20};
        tbl[5]  = '{1'b1,1'b1,1'b1,4'd7, 32'd4, 32'h8000_0000, 32'h11, 5'd9,5'd10,5'd20, 14'h24, 1'b0,5'd0,32'd0,
                    1'b1,1'b1,5'd20, 32'hF800_0000, 32'h11, 14'h24};
        tbl[6]  = '{1'b1,1'b1,1'b0,4'd8, 32'd0, 32'hFFFF_FFFF, 32'd1, 5'd11,5'd12,5'd21, 14'h28, 1'b0,5'd0,32'd0,
                    1'b1,1'b1,5'd21, 32'd1, 32'd1, 14'h28};
        tbl[7]  = '{1'b1,1'b1,1'b0,4'd9, 32'd0, 32'hFFFF_FFFF, 32'd1, 5'd11,5'd12,5'd22, 14'h2C, 1'b0,5'd0,32'd0,
                    1'b1,1'b1,5'd22, 32'd0, 32'd1, 14'h2C};
        tbl[8]  = '{1'b1,1'b1,1'b1,4'd5, 32'h3F, 32'd1, 32'd0, 5'd13,5'd14,5'd23, 14'h30, 1'b0,5'd0,32'd0,
                    1'b1,1'b1,5'd23, 32'h8000_0000, 32'd0, 14'h30};
        tbl[9]  = '{1'b1,1'b1,1'b0,4'd6, 32'd0, 32'h8000_0000, 32'h21, 5'd15,5'd16,5'd24, 14'h34, 1'b0,5'd0,32'd0,
                    1'b1,1'b1,5'd24, 32'h4000_0000, 32'h21, 14'h34};
        tbl[10] = '{1'b1,1'b1,1'b0,4'd13, 32'd0, 32'd5, 32'd6, 5'd17,5'd18,5'd25, 14'h38, 1'b0,5'd0,32'd0,
                    1'b1,1'b1,5'd25, 32'd0, 32'd6, 14'h38};
        tbl[11] = '{1'b0,1'b1,1'b0,4'd0, 32'd0, 32'd1, 32'd2, 5'd1,5'd2,5'd9, 14'h3C, 1'b0,5'd0,32'd0,
                    1'b0,1'b0,5'd0, 32'd0, 32'd0, 14'h0};
        tbl[12] = '{1'b1,1'b1,1'b1,4'd10, 32'h1234_5000, 32'd0, 32'd0, 5'd0,5'd0,5'd26, 14'h40, 1'b0,5'd0,32'd0,
                    1'b1,1'b1,5'd26, 32'h1234_5000, 32'd0, 14'h40};
        tbl[13] = '{1'b1,1'b1,1'b0,4'd4, 32'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd19,5'd1,5'd27, 14'h44, 1'b0,5'd0,32'd0,
                    1'b1,1'b1,5'd27, 32'h0FF0_0FF0, 32'hFF00_FF00, 14'h44};
        tbl[14] = '{1'b1,1'b1,1'b0,4'd1, 32'd0, 32'd0, 32'd1, 5'd2,5'd3,5'd28, 14'h48, 1'b0,5'd0,32'd0,
                    1'b1,1'b1,5'd28, 32'hFFFF_FFFF, 32'd1, 14'h48};
        tbl[15] = '{1'b1,1'b0,1'b0,4'd3, 32'd0, 32'h0F, 32'hF0, 5'd4,5'd5,5'd29, 14'h4C, 1'b0,5'd0,32'd0,
                    1'b1,1'b0,5'd29, 32'hFF, 32'hF0, 14'h4C};

        // reset, with a live ADD on the inputs that must be ignored
        idle_inputs();
        rst_n = 1'b0;
        valid_i = 1'b1; RegWrite_i = 1'b1; rd_i = 5'd3; rdata1_i = 32'd5; rdata2_i = 32'd7;
        step();
        step();
        chk_bubble("reset");
        chk("reset_stall", 32'(stall_o), 32'd0);
        idle_inputs();
        rst_n = 1'b1;
        step();

        // directed vectors
        for (int i = 0; i < 16; i++) begin
            valid_i = tbl[i].valid; RegWrite_i = tbl[i].rw; ALUSrc_i = tbl[i].alusrc;
            ALUControl_i = tbl[i].op; imme_i = tbl[i].imme; rdata1_i = tbl[i].rd1;
            rdata2_i = tbl[i].rd2; rs1_i = tbl[i].rs1; rs2_i = tbl[i].rs2; rd_i = tbl[i].rd;
            addr_i = tbl[i].addr; wb_regwrite_i = tbl[i].wb_rw; wb_rd_i = tbl[i].wb_rd;
            wb_data_i = tbl[i].wb_data;
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(stall_o), 32'd0);
            step();
            chk($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d_rw", i), 32'(RegWrite_o), 32'(tbl[i].e_rw));
            chk($sformatf("vec%0d_rd", i), 32'(rd_o), 32'(tbl[i].e_rd));
            chk($sformatf("vec%0d_result", i), result_o, tbl[i].e_res);
            chk($sformatf("vec%0d_store", i), store_data_o, tbl[i].e_store);
            chk($sformatf("vec%0d_addr", i), 32'(addr_o), 32'(tbl[i].e_addr));
        end
        idle_inputs();
        step();

        // MUL 0xFFFFFFFF * 3 with MEM/WB noise on rs1 after operands are latched
        set_mul(32'hFFFF_FFFF, 32'd3, 5'd7);
        stall_cnt = 0; done = 1'b0; edges = 0;
        for (int c = 1; c <= 40 && !done; c++) begin
            #1;
            if (stall_o) stall_cnt++;
            step();
            edges = c;
            wb_regwrite_i = 1'b1; wb_rd_i = 5'd1; wb_data_i = 32'd0;
            if (valid_o) begin
                done = 1'b1;
            end else begin
                chk("mul_bubble_result", result_o, 32'd0);
            end
        end
        chk("mul_latency", 32'(edges), 32'd33);
        chk("mul_stall_cycles", 32'(stall_cnt), 32'd32);
        chk("mul_result", result_o, 32'hFFFF_FFFD);
        chk("mul_rw", 32'(RegWrite_o), 32'd1);
        chk("mul_rd", 32'(rd_o), 32'd7);
        idle_inputs();
        step();

        // MUL flushed in its 10th cycle, then an ADD
        set_mul(32'd6, 32'd7, 5'd9);
        for (int c = 1; c <= 9; c++) begin
            #1;
            chk("flush_pre_stall", 32'(stall_o), 32'd1);
            step();
            chk("flush_pre_valid", 32'(valid_o), 32'd0);
        end
        flush_i = 1'b1;
        #1;
        chk("flush_stall", 32'(stall_o), 32'd0);
        step();
        chk_bubble("flush_out");
        idle_inputs();
        valid_i = 1'b1; RegWrite_i = 1'b1; ALUControl_i = ALU_ADD;
        rs1_i = 5'd1; rs2_i = 5'd2; rd_i = 5'd8; rdata1_i = 32'd2; rdata2_i = 32'd3; addr_i = 14'h50;
        #1;
        chk("post_flush_stall", 32'(stall_o), 32'd0);
        step();
        chk("post_flush_valid", 32'(valid_o), 32'd1);
        chk("post_flush_result", result_o, 32'd5);
        idle_inputs();
        for (int c = 0; c < 36; c++) begin
            step();
            chk("flush_no_ghost", 32'(valid_o), 32'd0);
        end

        // reset in the middle of a MUL
        set_mul(32'd9, 32'd9, 5'd10);
        for (int c = 0; c < 5; c++) step();
        rst_n = 1'b0;
        step();
        chk_bubble("rst_mid_mul");
        chk("rst_mid_mul_stall", 32'(stall_o), 32'd0);
        idle_inputs();
        rst_n = 1'b1;
        #1;
        chk("rst_release_stall", 32'(stall_o), 32'd0);
        for (int c = 0; c < 36; c++) begin
            step();
            chk("rst_no_ghost", 32'(valid_o), 32'd0);
        end

        // randomized run against the reference model
        m_valid = 1'b0; m_rw = 1'b0; m_rd = 5'd0; m_res = 32'd0; m_store = 32'd0;
        m_addr = 14'd0; m_prod = 32'd0; m_busy = 1'b0; m_left = 0; prev_stall = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!prev_stall) begin
                valid_i = ($urandom_range(0, 3) != 0);
                RegWrite_i = 1'($urandom_range(0, 1));
                ALUSrc_i = 1'($urandom_range(0, 1));
                ALUControl_i = ($urandom_range(0, 9) == 0) ? ALU_MUL : 4'($urandom_range(0, 15));
                imme_i = $urandom(); rdata1_i = $urandom(); rdata2_i = $urandom();
                rs1_i = 5'($urandom_range(0, 3)); rs2_i = 5'($urandom_range(0, 3));
                rd_i = 5'($urandom_range(0, 3)); addr_i = 14'($urandom());
            end
            wb_regwrite_i = 1'($urandom_range(0, 1));
            wb_rd_i = 5'($urandom_range(0, 3));
            wb_data_i = $urandom();
            flush_i = ($urandom_range(0, 29) == 0);
            fa = ref_fwd(rs1_i, rdata1_i);
            fb = ref_fwd(rs2_i, rdata2_i);
            bb = ALUSrc_i ? imme_i : fb;
            e_stall = !flush_i && (m_busy ? (m_left != 1) : (valid_i && ALUControl_i == ALU_MUL));
            #1;
            chk("rnd_stall", 32'(stall_o), 32'(e_stall));
            step();
            m_valid = 1'b0; m_rw = 1'b0; m_rd = 5'd0; m_res = 32'd0; m_store = 32'd0; m_addr = 14'd0;
            if (flush_i) begin
                m_busy = 1'b0;
            end else if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_valid = 1'b1; m_rw = RegWrite_i; m_rd = rd_i; m_res = m_prod;
                    m_store = fb; m_addr = addr_i;
                end
            end else if (valid_i && ALUControl_i == ALU_MUL) begin
                m_busy = 1'b1; m_left = 32; m_prod = fa * bb;
            end else if (valid_i) begin
                m_valid = 1'b1; m_rw = RegWrite_i; m_rd = rd_i; m_res = alu_ref(ALUControl_i, fa, bb);
                m_store = fb; m_addr = addr_i;
            end
            chk("rnd_valid", 32'(valid_o), 32'(m_valid));
            chk("rnd_rw", 32'(RegWrite_o), 32'(m_rw));
            chk("rnd_rd", 32'(rd_o), 32'(m_rd));
            chk("rnd_result", result_o, m_res);
            chk("rnd_store", store_data_o, m_store);
            chk("rnd_addr", 32'(addr_o), 32'(m_addr));
            prev_stall = e_stall;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
